// File: rtl/can_bit_timing_if.sv
// can_bit_timing_if: bus line, hard-sync enable and sampled-bit strobes between the bit-timing front end and the decoder
interface can_bit_timing_if;
    logic can_rx;
    logic hard_sync_en;
    logic rx_bit;
    logic sample_point;
    logic tx_point;
    modport master (output can_rx, hard_sync_en, input rx_bit, sample_point, tx_point);
    modport slave  (input can_rx, hard_sync_en, output rx_bit, sample_point, tx_point);
endinterface

// File: rtl/can_bit_timing.sv
// can_bit_timing: CAN bit timing with hard sync / SJW resync; define CAN_TRIPLE_SAMPLE_EN for 2-of-3 majority sampling
module can_bit_timing #(
    parameter int BRP   = 4,
    parameter int TSEG1 = 7,
    parameter int TSEG2 = 2,
    parameter int SJW   = 1
) (
    input logic             clock,
    input logic             reset,
    can_bit_timing_if.slave bus
);
    localparam logic [1:0] ST_SYNC = 2'd0, ST_SEG1 = 2'd1, ST_SEG2 = 2'd2;
    logic       meta_q, rx_sync_q, rx_prev_q, rx_bit_q, synced_q, synced_d;
    logic [1:0] st_q, st_d, e_st;
    logic [6:0] pre_q, pre_d;
    logic [4:0] tq_q, tq_d, len_q, len_d, shr_q, shr_d, shr_eff;
    logic [4:0] seg1_last, seg2_last, e_tq, len_amt;
    logic       tick, sp, samp, bit_now, fall, hard, rs, late, early, shorten, jump;

    assign tick      = pre_q == 7'(BRP - 1);
    assign seg1_last = 5'(TSEG1 - 1) + len_q;
    assign sp        = st_q == ST_SEG1 && tick && tq_q == seg1_last;
    assign bit_now   = sp ? samp : rx_bit_q;
    assign fall      = rx_prev_q & ~rx_sync_q;
    assign hard      = fall & bus.hard_sync_en;
    // a sample on the edge clock happens first, so the edge is judged as TSEG2 quantum 0 against the new bit
    assign rs        = fall & ~bus.hard_sync_en & bit_now & ~(synced_q & ~sp);
    assign e_st      = sp ? ST_SEG2 : st_q;
    assign e_tq      = sp ? 5'd0 : tq_q;
    assign late      = rs && e_st == ST_SEG1;
    assign early     = rs && e_st == ST_SEG2 && (5'(TSEG2) - e_tq) <= 5'(SJW);
    assign shorten   = rs && e_st == ST_SEG2 && !early;
    assign len_amt   = (e_tq + 5'd1 < 5'(SJW)) ? e_tq + 5'd1 : 5'(SJW);
    assign shr_eff   = shorten ? 5'(SJW) : shr_q;
    assign seg2_last = 5'(TSEG2 - 1) - shr_eff;
    assign jump      = hard | early;
    assign synced_d  = hard | rs | (synced_q & ~sp);

    assign bus.rx_bit       = bit_now;
    assign bus.sample_point = sp;
    assign bus.tx_point     = ~reset & ((st_q == ST_SYNC && pre_q == 7'd0) | jump);

`ifdef CAN_TRIPLE_SAMPLE_EN
    logic [1:0] tri_q;
    assign samp = (tri_q[1] & tri_q[0]) | (rx_sync_q & (tri_q[1] | tri_q[0]));
    // capture the line on the tq ticks of the two quanta preceding the sample point
    always_ff @(posedge clock or posedge reset)
        if (reset) tri_q <= 2'b11;
        else if (st_q == ST_SEG1 && tick && !sp && tq_q + 5'd2 >= seg1_last) tri_q <= {tri_q[0], rx_sync_q};
`else
    assign samp = rx_sync_q;
`endif

    // segment sequencing; a sync jump makes the edge clock act as SYNC and restarts TSEG1 next clock
    always_comb begin
        pre_d = tick ? 7'd0 : pre_q + 7'd1;
        st_d  = st_q;
        tq_d  = tq_q;
        len_d = late ? len_amt : len_q;
        shr_d = shr_eff;
        if (tick && st_q == ST_SYNC) begin
            st_d = ST_SEG1;
            tq_d = 5'd0;
        end else if (tick && st_q == ST_SEG1) begin
            st_d = sp ? ST_SEG2 : ST_SEG1;
            tq_d = sp ? 5'd0 : tq_q + 5'd1;
        end else if (tick && st_q == ST_SEG2) begin
            st_d  = tq_q == seg2_last ? ST_SYNC : ST_SEG2;
            tq_d  = tq_q == seg2_last ? 5'd0 : tq_q + 5'd1;
            len_d = tq_q == seg2_last ? 5'd0 : len_d;
            shr_d = tq_q == seg2_last ? 5'd0 : shr_d;
        end
        if (jump) begin
            pre_d = 7'd0;
            st_d  = ST_SEG1;
            tq_d  = 5'd0;
            len_d = 5'd0;
            shr_d = 5'd0;
        end
    end

    // synchroniser, timing state and sampled bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q    <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            pre_q     <= 7'd0;
            st_q      <= ST_SYNC;
            tq_q      <= 5'd0;
            len_q     <= 5'd0;
            shr_q     <= 5'd0;
            synced_q  <= 1'b0;
            rx_bit_q  <= 1'b1;
        end else begin
            meta_q    <= bus.can_rx;
            rx_sync_q <= meta_q;
            rx_prev_q <= rx_sync_q;
            pre_q     <= pre_d;
            st_q      <= st_d;
            tq_q      <= tq_d;
            len_q     <= len_d;
            shr_q     <= shr_d;
            synced_q  <= synced_d;
            rx_bit_q  <= bit_now;
        end
    end
endmodule

// File: tb/tb_can_bit_timing.sv
// tb_can_bit_timing: directed checks of bit timing, hard sync, resync, reset and sampling mode
module tb_can_bit_timing;
    localparam int NONE = 1 << 30;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   t = 0;
    int   checks = 0;
    int   fails = 0;
    int   tx0[$], tx1[$], sp0[$], sp1[$];
    logic b0[$], b1[$];

    can_bit_timing_if a ();
    can_bit_timing_if b ();

    can_bit_timing #(.BRP(4), .TSEG1(7), .TSEG2(2), .SJW(1)) dut1 (.clock(clock), .reset(reset), .bus(a.slave));
    can_bit_timing #(.BRP(4), .TSEG1(7), .TSEG2(2), .SJW(2)) dut2 (.clock(clock), .reset(reset), .bus(b.slave));

    always #5 clock = ~clock;

    function automatic int at(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic logic bt(logic q[$], int i);
        return (i < q.size()) ? q[i] : 1'bx;
    endfunction

    task automatic drive(input logic rx, input logic hs);
        a.can_rx = rx;
        b.can_rx = rx;
        a.hard_sync_en = hs;
        b.hard_sync_en = hs;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        t = 0;
        tx0.delete(); tx1.delete(); sp0.delete(); sp1.delete(); b0.delete(); b1.delete();
    endtask

    // t labels the clock cycle since reset release; line is dominant within [f1,r1) and [f2,r2)
    task automatic observe(input int n, input int f1, input int r1, input int f2, input int r2, input logic hs);
        repeat (n) begin
            @(negedge clock);
            if (a.tx_point) tx0.push_back(t);
            if (b.tx_point) tx1.push_back(t);
            if (a.sample_point) begin sp0.push_back(t); b0.push_back(a.rx_bit); end
            if (b.sample_point) begin sp1.push_back(t); b1.push_back(b.rx_bit); end
            drive(!((t >= f1 && t < r1) || (t >= f2 && t < r2)), hs);
            t++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++; if (a.tx_point !== 1'b0) begin fails++; $display("FAIL rst_tx got %b exp 0", a.tx_point); end
        checks++; if (a.sample_point !== 1'b0) begin fails++; $display("FAIL rst_sp got %b exp 0", a.sample_point); end
        checks++; if (a.rx_bit !== 1'b1) begin fails++; $display("FAIL rst_bit1 got %b exp 1", a.rx_bit); end
        checks++; if (b.rx_bit !== 1'b1) begin fails++; $display("FAIL rst_bit2 got %b exp 1", b.rx_bit); end
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checks++; if (a.tx_point !== 1'b1) begin fails++; $display("FAIL rel_tx1 got %b exp 1", a.tx_point); end
        checks++; if (b.tx_point !== 1'b1) begin fails++; $display("FAIL rel_tx2 got %b exp 1", b.tx_point); end
    endtask

    task automatic test_idle();
        do_reset();
        observe(400, NONE, NONE, NONE, NONE, 1'b0);
        checks++; if (tx0.size() != 10) begin fails++; $display("FAIL idle_ntx got %0d exp 10", tx0.size()); end
        checks++; if (sp0.size() != 10) begin fails++; $display("FAIL idle_nsp got %0d exp 10", sp0.size()); end
        checks++; if (tx1.size() != 10) begin fails++; $display("FAIL idle_ntx2 got %0d exp 10", tx1.size()); end
        foreach (tx0[i]) begin
            checks++; if (tx0[i] != 40 * i) begin fails++; $display("FAIL idle_tx[%0d] got %0d exp %0d", i, tx0[i], 40 * i); end
        end
        foreach (sp0[i]) begin
            checks++; if (sp0[i] != 40 * i + 31) begin fails++; $display("FAIL idle_sp[%0d] got %0d exp %0d", i, sp0[i], 40 * i + 31); end
            checks++; if (b0[i] !== 1'b1) begin fails++; $display("FAIL idle_bit[%0d] got %b exp 1", i, b0[i]); end
        end
    endtask

    task automatic test_hard_sync();
        do_reset();
        observe(45, 10, NONE, NONE, NONE, 1'b1);
        checks++; if (at(tx0, 1) != 12) begin fails++; $display("FAIL hs_tx1 got %0d exp 12", at(tx0, 1)); end
        checks++; if (at(sp0, 0) != 40) begin fails++; $display("FAIL hs_sp1 got %0d exp 40", at(sp0, 0)); end
        checks++; if (bt(b0, 0) !== 1'b0) begin fails++; $display("FAIL hs_bit1 got %b exp 0", bt(b0, 0)); end
        checks++; if (at(tx1, 1) != 12) begin fails++; $display("FAIL hs_tx2 got %0d exp 12", at(tx1, 1)); end
        checks++; if (at(sp1, 0) != 40) begin fails++; $display("FAIL hs_sp2 got %0d exp 40", at(sp1, 0)); end
    endtask

    task automatic test_late_edge();
        do_reset();
        observe(100, 10, NONE, NONE, NONE, 1'b0);
        checks++; if (at(sp0, 0) != 35) begin fails++; $display("FAIL late_sp1 got %0d exp 35", at(sp0, 0)); end
        checks++; if (bt(b0, 0) !== 1'b0) begin fails++; $display("FAIL late_bit1 got %b exp 0", bt(b0, 0)); end
        checks++; if (at(tx0, 1) != 44) begin fails++; $display("FAIL late_tx1 got %0d exp 44", at(tx0, 1)); end
        checks++; if (at(sp1, 0) != 39) begin fails++; $display("FAIL late_sp2 got %0d exp 39", at(sp1, 0)); end
        checks++; if (at(tx1, 1) != 48) begin fails++; $display("FAIL late_tx2 got %0d exp 48", at(tx1, 1)); end
    endtask

    task automatic test_early_edge();
        do_reset();
        observe(70, 34, 40, 46, NONE, 1'b0);
        checks++; if (at(sp0, 0) != 31) begin fails++; $display("FAIL early_sp0 got %0d exp 31", at(sp0, 0)); end
        checks++; if (at(tx0, 1) != 36) begin fails++; $display("FAIL early_tx1 got %0d exp 36", at(tx0, 1)); end
        checks++; if (at(tx1, 1) != 36) begin fails++; $display("FAIL early_tx2 got %0d exp 36", at(tx1, 1)); end
        checks++; if (at(sp0, 1) != 64) begin fails++; $display("FAIL early_second_sp1 got %0d exp 64", at(sp0, 1)); end
        checks++; if (at(sp1, 1) != 64) begin fails++; $display("FAIL early_second_sp2 got %0d exp 64", at(sp1, 1)); end
    endtask

    task automatic test_dom_to_dom();
        do_reset();
        observe(100, 10, 50, 56, NONE, 1'b0);
        checks++; if (at(sp0, 1) != 75) begin fails++; $display("FAIL d2d_sp1 got %0d exp 75", at(sp0, 1)); end
        checks++; if (at(sp1, 1) != 79) begin fails++; $display("FAIL d2d_sp2 got %0d exp 79", at(sp1, 1)); end
        checks++; if (at(tx0, 2) != 84) begin fails++; $display("FAIL d2d_tx1 got %0d exp 84", at(tx0, 2)); end
        checks++; if (at(tx1, 2) != 88) begin fails++; $display("FAIL d2d_tx2 got %0d exp 88", at(tx1, 2)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        observe(55, 10, NONE, NONE, NONE, 1'b0);
        checks++; if (a.rx_bit !== 1'b0) begin fails++; $display("FAIL mid_pre_bit got %b exp 0", a.rx_bit); end
        #2 reset = 1'b1;
        #1;
        checks++; if (a.rx_bit !== 1'b1) begin fails++; $display("FAIL mid_bit got %b exp 1", a.rx_bit); end
        checks++; if (a.sample_point !== 1'b0) begin fails++; $display("FAIL mid_sp got %b exp 0", a.sample_point); end
        checks++; if (a.tx_point !== 1'b0) begin fails++; $display("FAIL mid_tx got %b exp 0", a.tx_point); end
        checks++; if (b.rx_bit !== 1'b1) begin fails++; $display("FAIL mid_bit2 got %b exp 1", b.rx_bit); end
        do_reset();
        observe(40, NONE, NONE, NONE, NONE, 1'b0);
        checks++; if (at(tx0, 0) != 0) begin fails++; $display("FAIL mid_rel_tx got %0d exp 0", at(tx0, 0)); end
        checks++; if (at(sp0, 0) != 31) begin fails++; $display("FAIL mid_rel_sp got %0d exp 31", at(sp0, 0)); end
    endtask

    task automatic test_triple_sample();
        logic exp_bit;
`ifdef CAN_TRIPLE_SAMPLE_EN
        exp_bit = 1'b1;
`else
        exp_bit = 1'b0;
`endif
        do_reset();
        observe(85, 10, 50, 70, 74, 1'b0);
        checks++; if (at(sp0, 1) != 75) begin fails++; $display("FAIL tri_sp got %0d exp 75", at(sp0, 1)); end
        checks++; if (bt(b0, 1) !== exp_bit) begin fails++; $display("FAIL tri_bit got %b exp %b", bt(b0, 1), exp_bit); end
        checks++; if (bt(b1, 1) !== 1'b1) begin fails++; $display("FAIL tri_bit2 got %b exp 1", bt(b1, 1)); end
    endtask

    initial begin
        drive(1'b1, 1'b0);
        test_reset();
        test_idle();
        test_hard_sync();
        test_late_edge();
        test_early_edge();
        test_dom_to_dom();
        test_reset_mid();
        test_triple_sample();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
